// File: rtl/sum_window_acc.sv
// Windowed accumulator: sums WINDOW samples, tracks the peak, and holds the result on a valid/ready port.
// Define SUM_WINDOW_ACC_AVG_EN to present the truncating average instead of the raw total.
module sum_window_acc #(
  parameter int DATA_W = 8,
  parameter int WINDOW = 4,
  parameter int CNT_W  = $clog2(WINDOW),
  parameter int ACC_W  = DATA_W + CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              clr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [DATA_W-1:0] out_max,
  output logic              out_valid,
  input  logic              out_ready
);

  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);

  state_t             state, state_next;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  pk;

  logic               accept;
  logic [ACC_W-1:0]   total;
  logic [DATA_W-1:0]  pk_next;
  logic [ACC_W-1:0]   result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (ena) begin
      if (clr) begin
        state_next = ACCUM;
      end else begin
        unique case (state)
          ACCUM: if (in_valid && cnt == LAST) state_next = HOLD;
          HOLD:  if (out_ready)               state_next = ACCUM;
          default: state_next = ACCUM;
        endcase
      end
    end
  end

  always_comb begin
    in_ready  = (state == ACCUM) && ena && !clr;
    out_valid = (state == HOLD);
  end

  assign accept  = in_ready && in_valid;
  assign total   = acc + ACC_W'(in_data);
  assign pk_next = (in_data > pk) ? in_data : pk;

`ifdef SUM_WINDOW_ACC_AVG_EN
  assign result = total >> CNT_W;
`else
  assign result = total;
`endif

  // Final sample is folded into the result directly, so acc/pk restart at zero on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      cnt     <= '0;
      pk      <= '0;
      out_sum <= '0;
      out_max <= '0;
    end else if (ena) begin
      if (clr) begin
        acc <= '0;
        cnt <= '0;
        pk  <= '0;
      end else if (accept) begin
        if (cnt == LAST) begin
          out_sum <= result;
          out_max <= pk_next;
          acc     <= '0;
          cnt     <= '0;
          pk      <= '0;
        end else begin
          acc <= total;
          cnt <= cnt + CNT_W'(1);
          pk  <= pk_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_sum_window_acc.sv
// Directed bench for sum_window_acc (WINDOW=4, DATA_W=8) with a queue-based reference model.
module tb_sum_window_acc;

  localparam int DATA_W = 8;
  localparam int WINDOW = 4;
  localparam int ACC_W  = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ena = 1'b1;
  logic              clr = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [DATA_W-1:0] out_max;
  logic              out_valid;
  logic              out_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  sum_window_acc #(.DATA_W(DATA_W), .WINDOW(WINDOW)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_sum(out_sum), .out_max(out_max), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Reference model: collects the window's samples and computes total/peak arithmetically.
  logic [DATA_W-1:0] win_q[$];
  bit                m_hold = 0;
  int                m_sum  = 0;
  int                m_max  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q.delete();
      m_hold = 0;
      m_sum  = 0;
      m_max  = 0;
    end else if (ena) begin
      if (clr) begin
        win_q.delete();
        m_hold = 0;
      end else if (!m_hold && in_valid) begin
        win_q.push_back(in_data);
        if (win_q.size() == WINDOW) begin
          int t, mx;
          t  = 0;
          mx = 0;
          foreach (win_q[i]) begin
            t += int'(win_q[i]);
            if (int'(win_q[i]) > mx) mx = int'(win_q[i]);
          end
`ifdef SUM_WINDOW_ACC_AVG_EN
          m_sum = t / WINDOW;
`else
          m_sum = t;
`endif
          m_max  = mx;
          m_hold = 1;
          win_q.delete();
        end
      end else if (m_hold && out_ready) begin
        m_hold = 0;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("in_ready",  int'(in_ready),  int'(!m_hold && ena && !clr));
    check("out_valid", int'(out_valid), int'(m_hold));
    check("out_sum",   int'(out_sum),   m_sum);
    check("out_max",   int'(out_max),   m_max);
  end

  task automatic step(input bit e, input bit c, input bit v, input int d, input bit r);
    ena       = e;
    clr       = c;
    in_valid  = v;
    in_data   = DATA_W'(d);
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic window4(input int a, input int b, input int c, input int d, input bit r);
    step(1, 0, 1, a, r);
    step(1, 0, 1, b, r);
    step(1, 0, 1, c, r);
    step(1, 0, 1, d, r);
  endtask

  task automatic expect_result(input string name, input int raw, input int mx);
    check({name, "_valid"}, int'(out_valid), 1);
`ifdef SUM_WINDOW_ACC_AVG_EN
    check({name, "_sum"}, int'(out_sum), raw / 4);
`else
    check({name, "_sum"}, int'(out_sum), raw);
`endif
    check({name, "_max"}, int'(out_max), mx);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_sum", int'(out_sum), 0);
    check("rst_valid", int'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    window4(10, 20, 30, 40, 1);
    expect_result("basic", 100, 40);
    check("basic_in_ready", int'(in_ready), 0);
    step(1, 0, 0, 0, 1);
    check("basic_drop", int'(out_valid), 0);

    window4(255, 255, 255, 255, 1);
    expect_result("maxval", 1020, 255);
    step(1, 0, 0, 0, 1);
    window4(1, 2, 2, 2, 1);
    expect_result("trunc", 7, 2);
    step(1, 0, 0, 0, 1);

    window4(3, 4, 5, 6, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 1, 100 + i, 0);
      expect_result("bp_hold", 18, 6);
      check("bp_in_ready", int'(in_ready), 0);
    end
    step(1, 0, 1, 99, 1);
    window4(1, 2, 3, 4, 1);
    expect_result("bp_next", 10, 4);
    step(1, 0, 0, 0, 1);

    step(1, 0, 1, 5, 0);
    step(1, 0, 1, 7, 0);
    step(1, 1, 1, 200, 0);
    window4(1, 1, 1, 1, 0);
    expect_result("abort", 4, 1);
    step(1, 1, 0, 0, 0);
    check("clr_hold_valid", int'(out_valid), 0);

    step(1, 0, 1, 50, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 77, 1);
      check("freeze_valid", int'(out_valid), 0);
    end
    step(1, 0, 1, 60, 1);
    step(1, 0, 1, 70, 1);
    step(1, 0, 1, 80, 1);
    expect_result("freeze", 260, 80);
    step(0, 0, 0, 0, 1);
    check("freeze_hold", int'(out_valid), 1);
    step(1, 0, 0, 0, 1);

    window4(9, 9, 9, 9, 0);
    expect_result("pre_rst", 36, 9);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", int'(out_valid), 0);
    check("arst_sum", int'(out_sum), 0);
    check("arst_max", int'(out_max), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    window4(2, 2, 2, 2, 1);
    expect_result("post_rst", 8, 2);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sum_window_acc.md
# sum_window_acc

- Downstream consumer of the 8-bit adder output (`ui_in + uio_in`) in the tt_um top.
- Accepts one sum per valid/ready handshake and accumulates a window of WINDOW samples.
- Presents the window total (or average) and the window peak on a registered valid/ready output port.
- Holds the result until the consumer takes it, then restarts.

## Interface

Parameters:
- `DATA_W`, default 8: width of each input sample.
- `WINDOW`, default 4: samples per window; power of two, range 2..16.
- `CNT_W`, default `$clog2(WINDOW)`: width of the sample counter.
- `ACC_W`, default `DATA_W + CNT_W`: accumulator and result width.

Ports:
- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `ena`, input, 1: freeze when low. No handshake completes and no state changes; outputs hold.
- `clr`, input, 1: synchronous window abort. Highest priority after reset.
- `in_data`, input, DATA_W: sample, i.e. the adder result.
- `in_valid`, input, 1: `in_data` is valid this cycle.
- `in_ready`, output, 1: the block accepts a sample this cycle.
- `out_sum`, output, ACC_W: window total, or average when configured (see Configuration).
- `out_max`, output, DATA_W: largest sample seen in the window.
- `out_valid`, output, 1: `out_sum` and `out_max` are valid.
- `out_ready`, input, 1: the consumer takes the result this cycle.

## Operation

States: ACCUM and HOLD. Reset enters ACCUM.
- Internal registers: `acc` (ACC_W), `cnt` (CNT_W), `pk` (DATA_W). Output registers: `out_sum`, `out_max`.

ACCUM:
- `in_ready` = `ena` and not `clr`.
- `out_valid` = 0.
- Accept when `in_valid` and `in_ready`:
  - `acc` += `in_data`, zero-extended, unsigned.
  - `pk` = max(`pk`, `in_data`).
  - `cnt` += 1.
- On an accept with `cnt` == WINDOW-1:
  - Load `out_sum` from `acc + in_data` (final sample included). Load `out_max` from max(`pk`, `in_data`).
  - Reset `acc`, `cnt` and `pk` to 0. Go to HOLD.
- ACC_W holds WINDOW × (2^DATA_W − 1) exactly, so overflow is impossible and there is no wrap handling.

HOLD:
- `in_ready` = 0 and `out_valid` = 1.
- `out_sum` and `out_max` stay stable until the handshake completes.
- Handshake when `out_ready` and `ena`: go to ACCUM next cycle. `out_valid` drops to 0.
- The next sample can be accepted the cycle after the output handshake. There is no same-cycle bypass, which gives a 1-cycle bubble per window.

`clr` (sync, when `ena` = 1, any state):
- Zeroes `acc`, `cnt` and `pk` and forces ACCUM.
- A pending result in HOLD is discarded and `out_valid` = 0 next cycle.
- `clr` together with `in_valid`: the sample is not accepted, because `in_ready` = 0.
- `clr` is ignored while `ena` = 0.

`ena` = 0 overrides the handshakes: neither `in_valid` nor `out_ready` is honoured.

## Timing

- Reset values, asynchronous on `rst_n` low: state = ACCUM, `acc` = 0, `cnt` = 0, `pk` = 0, `out_sum` = 0, `out_max` = 0, `out_valid` = 0.
- `in_ready` is combinational from state, `ena` and `clr`. All other outputs are registered.
- Latency: the last accepted sample on edge N gives `out_valid` = 1 after edge N, i.e. on cycle N+1.
- Throughput: WINDOW+1 cycles per window minimum, with `out_ready` held high.
- Reset mid-window discards the partial accumulation. Reset in HOLD discards the result.
- A source holding `in_valid` with `in_ready` low stalls without loss. The block does not require `in_data` to stay stable while stalled.

## Configuration

- Macro `SUM_WINDOW_ACC_AVG_EN`.
  - Defined: `out_sum` = (window total >> CNT_W), zero-extended to ACC_W. This is a truncating average, taken in the same cycle as the load, so latency is unchanged.
  - Undefined: `out_sum` = raw window total.
- `out_max` and all handshake and timing behaviour are identical in both builds.

## Test plan

- Reset, WINDOW=4, raw build:
  - Stimulus: samples 10, 20, 30, 40 back-to-back with `out_ready` = 1.
  - Response: `out_valid` = 1 one cycle after the 40 is accepted, with `out_sum` = 100 and `out_max` = 40. `in_ready` = 0 during that cycle.
- Maximum values, raw build:
  - Stimulus: four samples of 255.
  - Response: `out_sum` = 1020 (10-bit, no wrap), `out_max` = 255.
  - Same stimulus with `SUM_WINDOW_ACC_AVG_EN` defined: `out_sum` = 255. Samples 1, 2, 2, 2 give `out_sum` = 1 (truncated).
- Output backpressure:
  - Stimulus: `out_ready` = 0 for 5 cycles after `out_valid` rises, with `in_valid` held high and new data throughout.
  - Response: `out_sum` and `out_max` stable, `in_ready` = 0, and no sample absorbed. After `out_ready` = 1, the next window starts cleanly from 0.
- Abort:
  - Stimulus: `clr` after 2 of 4 samples (5 and 7), then 1, 1, 1, 1.
  - Response: `out_sum` = 4, `out_max` = 1.
  - Stimulus: `clr` while in HOLD. Response: `out_valid` = 0 next cycle.
- Freeze:
  - Stimulus: `ena` = 0 for 3 cycles mid-window, with `in_valid` and `out_ready` high.
  - Response: `in_ready` = 0, `cnt`, `acc` and the outputs unchanged. The window resumes and totals correctly once `ena` = 1.
- Asynchronous reset:
  - Stimulus: assert `rst_n` low between clock edges while in HOLD.
  - Response: `out_valid`, `out_sum` and `out_max` go to 0 immediately, with no clock edge required.
